// File: rtl/psram_cmd_scheduler.sv
// psram_cmd_scheduler: queues UART read/write commands and issues them one at a time to the PSRAM controller, relaying read data to the UART transmitter.
// Latency: a command accepted at edge N into an empty queue while idle gives psram_start in the cycle after edge N+2.
// Backpressure: cmd_ready = !full (occupancy only); the sequencer stalls on psram_done (bounded by TIMEOUT_CYCLES) and on tx_busy.
// Ports: cmd_* from the UART parser; psram_* handshake with the PSRAM controller; tx_* to the UART transmitter;
//        err_cmd (illegal op pulse), timeout_err (sticky), fifo_level (queue occupancy).
module psram_cmd_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 23,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_PSRAM,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_rw,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    input  logic [DATA_WIDTH-1:0]       cmd_data,
    output logic                        psram_start,
    output logic [1:0]                  psram_read_write,
    output logic [ADDR_WIDTH-1:0]       psram_address,
    output logic [DATA_WIDTH-1:0]       psram_data_in,
    input  logic                        psram_done,
    input  logic [DATA_WIDTH-1:0]       psram_data_out,
    output logic                        tx_send,
    output logic [DATA_WIDTH-1:0]       tx_msg,
    input  logic                        tx_busy,
    output logic                        err_cmd,
    output logic                        timeout_err,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    typedef struct packed {
        logic [1:0]            rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_SEND_TX,
        S_WAIT_TX
    } state_t;

    state_t                state_q, state_d;
    cmd_t                  mem_q [FIFO_DEPTH];
    cmd_t                  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    cmd_t                  issued_q, issued_d;
    logic                  start_q, start_d;
    logic                  tx_send_q, tx_send_d;
    logic [DATA_WIDTH-1:0] tx_msg_q, tx_msg_d;
    logic                  err_cmd_q, err_cmd_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_first_q, tx_first_d;

    logic full, empty, accept, legal, push, pop;

    // Acceptance looks only at occupancy, so a full queue refuses even when it pops this cycle.
    always_comb begin
        full   = (level_q == LVL_W'(FIFO_DEPTH));
        empty  = (level_q == '0);
        accept = cmd_valid && !full;
        legal  = (cmd_rw == OP_WRITE) || (cmd_rw == OP_READ);
        push   = accept && legal;
        pop    = (state_q == S_IDLE) && !empty;
    end

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        issued_d      = issued_q;
        start_d       = 1'b0;
        tx_send_d     = 1'b0;
        tx_msg_d      = tx_msg_q;
        err_cmd_d     = accept && !legal;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        tx_first_d    = tx_first_q;

        if (push) begin
            mem_d[wr_ptr_q] = {cmd_rw, cmd_addr, cmd_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    issued_d = mem_q[rd_ptr_q];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion takes priority over a timeout landing in the same cycle.
                if (psram_done) begin
                    if (issued_q.rw == OP_READ) begin
                        tx_msg_d = psram_data_out;
                        state_d  = S_SEND_TX;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_SEND_TX: begin
                if (!tx_busy) begin
                    tx_send_d  = 1'b1;
                    tx_first_d = 1'b1;
                    state_d    = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // The transmitter raises busy one cycle after tx_send, so the first cycle's busy is meaningless.
                if (tx_first_q) begin
                    tx_first_d = 1'b0;
                end else if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            issued_q      <= '0;
            start_q       <= 1'b0;
            tx_send_q     <= 1'b0;
            tx_msg_q      <= '0;
            err_cmd_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            tx_first_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            issued_q      <= issued_d;
            start_q       <= start_d;
            tx_send_q     <= tx_send_d;
            tx_msg_q      <= tx_msg_d;
            err_cmd_q     <= err_cmd_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            tx_first_q    <= tx_first_d;
        end
    end

    assign cmd_ready        = !full;
    assign psram_start      = start_q;
    assign psram_read_write = issued_q.rw;
    assign psram_address    = issued_q.addr;
    assign psram_data_in    = issued_q.data;
    assign tx_send          = tx_send_q;
    assign tx_msg           = tx_msg_q;
    assign err_cmd          = err_cmd_q;
    assign timeout_err      = timeout_err_q;
    assign fifo_level       = level_q;

endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// tb_psram_cmd_scheduler: directed, table-driven bench for psram_cmd_scheduler with TIMEOUT_CYCLES = 16.
// Inputs change 1 time unit after each rising edge; outputs are read at the same point or on the falling edge.
// The bench plays both the PSRAM controller (psram_done) and the UART transmitter (tx_busy).
module tb_psram_cmd_scheduler;

    logic        clk_PSRAM;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_rw;
    logic [22:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        psram_start;
    logic [1:0]  psram_read_write;
    logic [22:0] psram_address;
    logic [15:0] psram_data_in;
    logic        psram_done;
    logic [15:0] psram_data_out;
    logic        tx_send;
    logic [15:0] tx_msg;
    logic        tx_busy;
    logic        err_cmd;
    logic        timeout_err;
    logic [2:0]  fifo_level;

    psram_cmd_scheduler #(
        .FIFO_DEPTH    (4),
        .ADDR_WIDTH    (23),
        .DATA_WIDTH    (16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_PSRAM       (clk_PSRAM),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_rw          (cmd_rw),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .psram_start     (psram_start),
        .psram_read_write(psram_read_write),
        .psram_address   (psram_address),
        .psram_data_in   (psram_data_in),
        .psram_done      (psram_done),
        .psram_data_out  (psram_data_out),
        .tx_send         (tx_send),
        .tx_msg          (tx_msg),
        .tx_busy         (tx_busy),
        .err_cmd         (err_cmd),
        .timeout_err     (timeout_err),
        .fifo_level      (fifo_level)
    );

    initial clk_PSRAM = 1'b0;
    always #5 clk_PSRAM = ~clk_PSRAM;

    int n_checks;
    int n_fail;
    int start_cnt;
    int send_cnt;
    int tx_viol;
    logic [22:0] issued_q[$];

    initial begin
        start_cnt = 0;
        send_cnt  = 0;
        tx_viol   = 0;
    end

    always @(negedge clk_PSRAM) begin
        if (psram_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            issued_q.push_back(psram_address);
        end
        if (tx_send === 1'b1) send_cnt = send_cnt + 1;
        if (tx_send === 1'b1 && tx_busy === 1'b1) tx_viol = tx_viol + 1;
    end

    typedef struct {
        logic [1:0]  rw;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          done_dly;
        int          busy_len;
        logic        exp_err;
        int          exp_issue;
        int          exp_sends;
        logic [15:0] exp_msg;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_PSRAM);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] rw, input logic [22:0] addr, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [15:0] rdata);
        psram_data_out = rdata;
        psram_done     = 1'b1;
        tick();
        psram_done     = 1'b0;
        psram_data_out = 16'h0;
    endtask

    task automatic wait_start(input int max_cyc);
        int c;
        c = 0;
        while (psram_start !== 1'b1 && c < max_cyc) begin
            tick();
            c++;
        end
        check("start_seen", 64'(psram_start), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    int s0, t0;
    int bp_base;
    logic [22:0] bp_addr[6];

    initial begin
        vecs[0] = '{2'd1, 23'h000123, 16'hBEEF, 16'h0000, 5, 0, 1'b0, 1, 0, 16'h0000};
        vecs[1] = '{2'd3, 23'h000456, 16'h1111, 16'h0000, 0, 0, 1'b1, 0, 0, 16'h0000};
        vecs[2] = '{2'd2, 23'h000010, 16'h0000, 16'h3C3C, 2, 4, 1'b0, 1, 1, 16'h3C3C};
        vecs[3] = '{2'd0, 23'h7FFFFF, 16'hFFFF, 16'h0000, 0, 0, 1'b1, 0, 0, 16'h0000};
        vecs[4] = '{2'd1, 23'h555555, 16'h0001, 16'h0000, 1, 0, 1'b0, 1, 0, 16'h0000};
        vecs[5] = '{2'd2, 23'h2AAAAA, 16'h0000, 16'hFFFF, 0, 1, 1'b0, 1, 1, 16'hFFFF};
        bp_addr[0] = 23'h000100;
        bp_addr[1] = 23'h000200;
        bp_addr[2] = 23'h000300;
        bp_addr[3] = 23'h000400;
        bp_addr[4] = 23'h000500;
        bp_addr[5] = 23'h000600;

        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_rw         = 2'd0;
        cmd_addr       = 23'h0;
        cmd_data       = 16'h0;
        psram_done     = 1'b0;
        psram_data_out = 16'h0;
        tx_busy        = 1'b0;

        // Reset state
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_psram_start", 64'(psram_start), 64'd0);
        check("rst_psram_address", 64'(psram_address), 64'd0);
        check("rst_tx_send", 64'(tx_send), 64'd0);
        check("rst_tx_msg", 64'(tx_msg), 64'd0);
        check("rst_err_cmd", 64'(err_cmd), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        @(posedge clk_PSRAM);
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // Single-command vectors
        for (int i = 0; i < NV; i++) begin
            s0 = start_cnt;
            t0 = send_cnt;
            push_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].exp_err) begin
                check("err_cmd_pulse", 64'(err_cmd), 64'd1);
                check("illegal_level", 64'(fifo_level), 64'd0);
                tick();
                check("err_cmd_drop", 64'(err_cmd), 64'd0);
            end else begin
                check("err_cmd_quiet", 64'(err_cmd), 64'd0);
                check("push_level", 64'(fifo_level), 64'd1);
                tick();
                check("pop_level", 64'(fifo_level), 64'd0);
                check("start_early", 64'(psram_start), 64'd0);
                check("issue_rw", 64'(psram_read_write), 64'(vecs[i].rw));
                check("issue_addr", 64'(psram_address), 64'(vecs[i].addr));
                check("issue_data", 64'(psram_data_in), 64'(vecs[i].wdata));
                tick();
                check("start_pulse", 64'(psram_start), 64'd1);
                repeat (vecs[i].done_dly) tick();
                done_pulse(vecs[i].rdata);
                if (vecs[i].rw == 2'd2) begin
                    check("tx_msg", 64'(tx_msg), 64'(vecs[i].exp_msg));
                    tick();
                    check("tx_send_pulse", 64'(tx_send), 64'd1);
                    tick();
                    check("tx_send_drop", 64'(tx_send), 64'd0);
                    tx_busy = 1'b1;
                    repeat (vecs[i].busy_len) tick();
                    tx_busy = 1'b0;
                end
            end
            repeat (4) tick();
            check("vec_start_count", 64'(start_cnt - s0), 64'(vecs[i].exp_issue));
            check("vec_send_count", 64'(send_cnt - t0), 64'(vecs[i].exp_sends));
        end

        // Read round trip with a write queued behind it
        push_cmd(2'd2, 23'h7FFFFF, 16'h0000);
        push_cmd(2'd1, 23'h000055, 16'h1111);
        tick();
        check("rd_start", 64'(psram_start), 64'd1);
        check("rd_addr", 64'(psram_address), 64'h7FFFFF);
        check("rd_rw", 64'(psram_read_write), 64'd2);
        repeat (3) tick();
        done_pulse(16'hA55A);
        check("rd_tx_msg", 64'(tx_msg), 64'hA55A);
        t0 = send_cnt;
        tick();
        s0 = start_cnt;
        check("rd_tx_send", 64'(tx_send), 64'd1);
        tick();
        tx_busy = 1'b1;
        repeat (20) tick();
        check("rd_no_start_while_busy", 64'(start_cnt - s0), 64'd0);
        check("rd_queued_level", 64'(fifo_level), 64'd1);
        tx_busy = 1'b0;
        tick();
        tick();
        check("rd_next_not_yet", 64'(psram_start), 64'd0);
        check("rd_next_addr", 64'(psram_address), 64'h000055);
        tick();
        check("rd_next_start", 64'(psram_start), 64'd1);
        repeat (2) tick();
        done_pulse(16'h0000);
        repeat (4) tick();
        check("rd_send_count", 64'(send_cnt - t0), 64'd1);

        // Backpressure and ordering
        bp_base = issued_q.size();
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1;
            cmd_rw    = 2'd1;
            cmd_addr  = bp_addr[k];
            cmd_data  = 16'(k);
            tick();
        end
        check("bp_full_level", 64'(fifo_level), 64'd4);
        check("bp_ready_low", 64'(cmd_ready), 64'd0);
        cmd_addr = bp_addr[5];
        cmd_data = 16'h0005;
        tick();
        tick();
        check("bp_held_level", 64'(fifo_level), 64'd4);
        psram_done = 1'b1;
        tick();
        psram_done = 1'b0;
        tick();
        check("bp_pop_no_accept", 64'(fifo_level), 64'd3);
        check("bp_second_addr", 64'(psram_address), 64'(bp_addr[1]));
        tick();
        check("bp_late_accept", 64'(fifo_level), 64'd4);
        cmd_valid = 1'b0;
        for (int k = 1; k < 6; k++) begin
            wait_start(20);
            repeat (2) tick();
            done_pulse(16'h0000);
        end
        repeat (4) tick();
        check("bp_issue_count", 64'(issued_q.size() - bp_base), 64'd6);
        for (int k = 0; k < 6; k++) begin
            if (bp_base + k < issued_q.size())
                check("bp_order", 64'(issued_q[bp_base + k]), 64'(bp_addr[k]));
        end
        check("bp_no_timeout", 64'(timeout_err), 64'd0);

        // Timeout
        push_cmd(2'd1, 23'h001000, 16'hCAFE);
        push_cmd(2'd2, 23'h002000, 16'h0000);
        tick();
        check("to_start", 64'(psram_start), 64'd1);
        repeat (15) tick();
        check("to_not_early", 64'(timeout_err), 64'd0);
        tick();
        check("to_rise", 64'(timeout_err), 64'd1);
        repeat (2) tick();
        check("to_next_start", 64'(psram_start), 64'd1);
        check("to_next_addr", 64'(psram_address), 64'h002000);
        repeat (16) tick();
        check("to_sticky", 64'(timeout_err), 64'd1);
        check("to_level", 64'(fifo_level), 64'd0);
        s0 = start_cnt;
        t0 = send_cnt;
        done_pulse(16'h1234);
        repeat (6) tick();
        check("to_late_done_no_send", 64'(send_cnt - t0), 64'd0);
        check("to_late_done_msg", 64'(tx_msg), 64'hA55A);
        check("to_late_done_no_start", 64'(start_cnt - s0), 64'd0);

        // Asynchronous reset during WAIT_TX with two commands queued
        push_cmd(2'd2, 23'h000AAA, 16'h0000);
        push_cmd(2'd1, 23'h000BBB, 16'h2222);
        push_cmd(2'd1, 23'h000CCC, 16'h3333);
        check("ar_start", 64'(psram_start), 64'd1);
        repeat (2) tick();
        done_pulse(16'h0F0F);
        tick();
        check("ar_tx_send", 64'(tx_send), 64'd1);
        tick();
        tx_busy = 1'b1;
        repeat (2) tick();
        check("ar_level_before", 64'(fifo_level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_fifo_level", 64'(fifo_level), 64'd0);
        check("ar_cmd_ready", 64'(cmd_ready), 64'd1);
        check("ar_psram_start", 64'(psram_start), 64'd0);
        check("ar_psram_rw", 64'(psram_read_write), 64'd0);
        check("ar_psram_address", 64'(psram_address), 64'd0);
        check("ar_psram_data_in", 64'(psram_data_in), 64'd0);
        check("ar_tx_send", 64'(tx_send), 64'd0);
        check("ar_tx_msg", 64'(tx_msg), 64'd0);
        check("ar_err_cmd", 64'(err_cmd), 64'd0);
        check("ar_timeout_err", 64'(timeout_err), 64'd0);
        repeat (2) tick();
        s0 = start_cnt;
        t0 = send_cnt;
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        repeat (30) tick();
        check("ar_no_start_after", 64'(start_cnt - s0), 64'd0);
        check("ar_no_send_after", 64'(send_cnt - t0), 64'd0);
        check("ar_level_after", 64'(fifo_level), 64'd0);

        check("tx_send_while_busy", 64'(tx_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psram_cmd_scheduler.md
Name: psram_cmd_scheduler

Overview:
- Sequences PSRAM accesses between the UART command front-end and the PSRAM controller.
- Queues decoded read/write commands in a small FIFO and issues them one at a time to the PSRAM controller with a start pulse, then waits for completion.
- Forwards each read result to the UART transmitter and waits for that transmission to finish before issuing the next command.
- Provides flow control, command-error flagging and a completion timeout.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, at least 2.
- ADDR_WIDTH, 23, PSRAM word address width.
- DATA_WIDTH, 16, PSRAM data word width.
- TIMEOUT_CYCLES, 1024, maximum cycles allowed in WAIT_DONE before the command is abandoned.

Ports:
- clk_PSRAM  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present from UART parser.
- cmd_ready  out  1  scheduler can accept a command (FIFO not full).
- cmd_rw  in  2  1 = write, 2 = read, 0 and 3 are illegal.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_data  in  DATA_WIDTH  write data; ignored for reads.
- psram_start  out  1  one-cycle issue pulse to the PSRAM controller.
- psram_read_write  out  2  operation code of the issued command.
- psram_address  out  ADDR_WIDTH  address of the issued command.
- psram_data_in  out  DATA_WIDTH  write data of the issued command.
- psram_done  in  1  one-cycle completion pulse from the PSRAM controller.
- psram_data_out  in  DATA_WIDTH  read data, valid when psram_done is high.
- tx_send  out  1  one-cycle request to the UART transmitter.
- tx_msg  out  DATA_WIDTH  word to transmit.
- tx_busy  in  1  UART transmitter active.
- err_cmd  out  1  one-cycle pulse when an illegal cmd_rw is accepted.
- timeout_err  out  1  sticky flag; cleared only by reset.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0 except cmd_ready = 1;
  - FIFO empty, pointers 0, state IDLE, timeout counter 0.
- Accept and push:
  - A command is accepted when cmd_valid && cmd_ready at a clock edge.
  - cmd_ready = !full; it is derived from occupancy and does not depend on a same-cycle pop. When full, nothing is accepted even if a pop occurs in that cycle.
  - An accepted command with cmd_rw of 0 or 3 is not pushed. err_cmd pulses high in the following cycle.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop in the same cycle leaves fifo_level unchanged.
- States:
  - IDLE: if the FIFO is not empty, pop the head, register it onto psram_read_write, psram_address and psram_data_in, and go to ISSUE. These outputs hold until the next pop.
  - ISSUE: psram_start = 1 for exactly this one cycle. Clear the timeout counter. Go to WAIT_DONE.
  - WAIT_DONE: increment the timeout counter every cycle.
    - On psram_done: if the op is a write, go to IDLE. If it is a read, capture psram_data_out into tx_msg and go to SEND_TX.
    - If the counter reaches TIMEOUT_CYCLES-1 without psram_done: set timeout_err, drop the command, go to IDLE.
    - If psram_done arrives in the same cycle the counter reaches its limit, psram_done wins.
  - SEND_TX: wait while tx_busy = 1. When tx_busy = 0, pulse tx_send for one cycle and go to WAIT_TX.
  - WAIT_TX: ignore tx_busy in the first cycle, because the transmitter asserts busy the cycle after tx_send. After that, go to IDLE on the first cycle with tx_busy = 0.
- Latency:
  - Command accepted at edge N into an empty FIFO with state IDLE: pop at edge N+1, psram_start high during the cycle after edge N+2.
  - Write done pulse at edge M: the next queued command's psram_start follows 3 cycles later.
- Ordering and isolation:
  - Commands are issued strictly in FIFO order.
  - psram_done outside WAIT_DONE is ignored.
  - tx_send is never issued while tx_busy = 1.
- Reset mid-operation: the state returns to IDLE immediately, queued commands are discarded, and no further psram_start or tx_send is generated.

Test Plan:
- Single write: cmd_rw=1, addr=0x000123, data=0xBEEF. Required: one psram_start pulse with outputs 1/0x000123/0xBEEF. psram_done 5 cycles later. Back in IDLE; tx_send never asserted.
- Read round trip: cmd_rw=2, addr=0x7FFFFF. Controller returns psram_data_out=0xA55A with psram_done. Required: tx_msg=0xA55A and exactly one tx_send pulse. tx_busy is held 20 cycles; no new psram_start until tx_busy falls.
- Backpressure and ordering: with psram_done withheld, push 5 commands with cmd_valid held. Required: cmd_ready=0 when fifo_level=4 (one command in flight plus 4 queued). After releasing done pulses, psram_address follows exact push order.
- Illegal command: cmd_rw=3 accepted. Required: err_cmd high for 1 cycle, fifo_level stays 0, no psram_start.
- Timeout: TIMEOUT_CYCLES=16, psram_done never asserted. Required: timeout_err rises 16 cycles after psram_start, stays high, and the next queued command is issued. A late psram_done is ignored.
- Async reset: assert rst_n low during WAIT_TX with 2 commands queued. Required: fifo_level=0, cmd_ready=1, all other outputs 0 immediately, and no pulses after release.
